// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: instruction/PC widths, fetch FSM states,
// and the fetch-queue entry layout.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    typedef enum logic {
        FQ_RUN    = 1'b0,
        FQ_REFILL = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fq_entry_t;

    // Fetch addresses are word aligned; the low two bits of a target are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetched {instr, pc} entries with push/pop/clear.
// The head reads as all zeros while the buffer is empty.
module fq_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  fq_entry_t                push_data_i,
    input  logic                     pop_i,
    output fq_entry_t                head_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t          mem_q [DEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o      = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign occupancy_o = count_q;

    // The fetch credit rule must make a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (!rst_ni)
        !(push_i && !clear_i && !pop_i && count_q == (AW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited reads
// and buffers responses. Optional counters under FETCH_QUEUE_PERF_EN.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_W-1:0]       instr,
    output logic [PC_W-1:0]          instr_pc,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]              perf_stall_cycles,
    output logic [15:0]              perf_flushes
`endif
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [AW+1:0]   DEPTH_W   = (AW+2)'(DEPTH);
    localparam logic [PC_W-1:0] PC_STEP_W = PC_W'(PC_STEP);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]  resp_pc_q, resp_pc_d;
    logic             inflight_q, inflight_d;
    logic             has_room;
    logic             pop;
    fq_entry_t        head;

    assign has_room  = ({1'b0, occupancy} + (AW+2)'(inflight_q)) < DEPTH_W;

    // Gated by reset so no request leaks out while the block is held in reset.
    assign imem_req  = reset & ((state_q == FQ_REFILL) ? ~redirect_valid : has_room);
    assign imem_addr = fetch_pc_q;

    assign instr_valid = (occupancy != '0) & ~redirect_valid;
    assign pop         = instr_valid & instr_ready;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = 1'b0;
        state_d    = FQ_RUN;
        if (imem_req) begin
            fetch_pc_d = fetch_pc_q + PC_STEP_W;
            resp_pc_d  = fetch_pc_q;
            inflight_d = 1'b1;
        end
        // A redirect marks the outstanding response stale and restarts at the target.
        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_pc);
            inflight_d = 1'b0;
            state_d    = FQ_REFILL;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FQ_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_ni      (reset),
        .clear_i     (redirect_valid),
        .push_i      (inflight_q),
        .push_data_i ('{instr: imem_rdata, pc: resp_pc_q}),
        .pop_i       (pop),
        .head_o      (head),
        .occupancy_o (occupancy)
    );

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (instr_valid && !instr_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (redirect_valid && flush_q != '1)              flush_q <= flush_q + 16'd1;
        end
    end

    assign perf_stall_cycles = stall_q;
    assign perf_flushes      = flush_q;
`endif

endmodule
